display_scan_4dig: RTL and testbench

DISPLAY_SCAN_4DIG -- requirements
Module: display_scan_4dig

---
 rtl/display_scan_4dig.sv | 127 ++++++++++++
 tb/tb_display_scan_4dig.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_4dig.sv
// Four-digit multiplexed BCD display scanner with per-slot anode blanking,
// frame-synchronous data update and optional leading-zero suppression.
module display_scan_4dig #(
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic        lz_en,
    output logic        bcd_d,
    output logic        bcd_c,
    output logic        bcd_b,
    output logic        bcd_a,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       idx_reg, idx_next;
    logic [15:0]      hold_reg, hold_next;
    logic [15:0]      disp_reg, disp_next;
    logic             pend_reg, pend_next;
    logic             load_q_reg;
    logic [3:0]       an_reg, an_next;
    logic [3:0]       bcd_reg, bcd_next;
    logic             frame_done_reg, frame_done_next;

    logic             tick;
    logic             boundary;
    logic             capture;
    logic             in_blank;
    logic [3:0]       zero_from;
    logic [3:0]       suppress;

    generate
        if (BLANK_CYC == 0) begin : g_blank_none
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = cnt_reg < CNT_W'(BLANK_CYC);
        end
    endgenerate

    // A digit is blank-able when it and every more significant nibble are zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign zero_from[gi] = (disp_reg[15:gi*4] == '0);
            if (gi == 0) begin : g_lsd
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                assign suppress[gi] = lz_en && zero_from[gi];
            end
        end
    endgenerate

    always_comb begin
        tick     = en && (cnt_reg == CNT_MAX);
        boundary = tick && (idx_reg == 2'd3);
        capture  = load && !load_q_reg;

        cnt_next = cnt_reg;
        idx_next = idx_reg;
        if (en) begin
            if (tick) begin
                cnt_next = '0;
                idx_next = idx_reg + 2'd1;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end

        // Copy uses the old holding value, so a coincident load stays pending.
        hold_next = hold_reg;
        disp_next = disp_reg;
        pend_next = pend_reg;
        if (pend_reg && (boundary || !en)) begin
            disp_next = hold_reg;
            pend_next = 1'b0;
        end
        if (capture) begin
            hold_next = digits_in;
            pend_next = 1'b1;
        end

        bcd_next = en ? disp_reg[{idx_reg, 2'b00} +: 4] : bcd_reg;
        an_next  = 4'b1111;
        if (en && !in_blank && !suppress[idx_reg]) begin
            an_next[idx_reg] = 1'b0;
        end
        frame_done_next = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            idx_reg        <= 2'd0;
            hold_reg       <= 16'h0000;
            disp_reg       <= 16'h0000;
            pend_reg       <= 1'b0;
            load_q_reg     <= 1'b0;
            an_reg         <= 4'b1111;
            bcd_reg        <= 4'b0000;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            hold_reg       <= hold_next;
            disp_reg       <= disp_next;
            pend_reg       <= pend_next;
            load_q_reg     <= load;
            an_reg         <= an_next;
            bcd_reg        <= bcd_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign {bcd_d, bcd_c, bcd_b, bcd_a} = bcd_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_display_scan_4dig.sv
// Bench for display_scan_4dig: frame-position reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_display_scan_4dig;

    localparam int P  = 4;
    localparam int B  = 1;
    localparam int FR = 4 * P;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic        lz_en;
    logic        bcd_d, bcd_c, bcd_b, bcd_a;
    logic [3:0]  an;
    logic        frame_done;
    logic [3:0]  bcd;

    assign bcd = {bcd_d, bcd_c, bcd_b, bcd_a};

    display_scan_4dig #(.PRESCALE(P), .BLANK_CYC(B)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
        .lz_en(lz_en), .bcd_d(bcd_d), .bcd_c(bcd_c), .bcd_b(bcd_b), .bcd_a(bcd_a),
        .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Model: position within the frame plus the data registers.
    int          m_pos;
    logic [15:0] m_hold, m_disp;
    logic        m_pend, m_lprev;
    logic [3:0]  exp_an, exp_bcd;
    logic        exp_fd;

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_hold = 16'h0; m_disp = 16'h0; m_pend = 1'b0; m_lprev = 1'b0;
        exp_an = 4'hF; exp_bcd = 4'h0; exp_fd = 1'b0;
    endtask

    task automatic model_step();
        int dig, sub, dv;
        bit sup, cap;
        if (!rst_n) begin
            model_reset();
        end else begin
            dig = m_pos / P;
            sub = m_pos % P;
            dv  = int'(m_disp);
            if (en) begin
                exp_bcd = 4'((dv >> (4 * dig)) % 16);
                sup     = lz_en && (dig > 0) && ((dv >> (4 * dig)) == 0);
                exp_an  = (sub < B || sup) ? 4'hF : (4'hF ^ (4'd1 << dig));
            end else begin
                exp_an = 4'hF;
            end
            exp_fd = en && (m_pos == FR - 1);
            cap = load && !m_lprev;
            if (m_pend && (!en || m_pos == FR - 1)) begin
                m_disp = m_hold;
                m_pend = 1'b0;
            end
            if (cap) begin
                m_hold = digits_in;
                m_pend = 1'b1;
            end
            m_lprev = load;
            if (en) m_pos = (m_pos + 1) % FR;
        end
    endtask

    task automatic cyc(input logic e, input logic l, input logic [15:0] d, input logic lz);
        en = e; load = l; digits_in = d; lz_en = lz;
        model_step();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_on) begin
            check("an", {12'h0, an}, {12'h0, exp_an});
            check("bcd", {12'h0, bcd}, {12'h0, exp_bcd});
            check("frame_done", {15'h0, frame_done}, {15'h0, exp_fd});
        end
    end

    logic [3:0] an_tab [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    logic [3:0] bcd_tab [16] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2,
                                 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4};

    initial begin
        int n_hi, n1, n0, n_other, n_bad1, n_bad2;
        logic [15:0] d;
        logic lz_r;

        rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = 16'h0; lz_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_an", {12'h0, an}, 16'hF);
        check("reset_bcd", {12'h0, bcd}, 16'h0);
        check("reset_fd", {15'h0, frame_done}, 16'h0);
        model_reset();
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Load 4321 at cycle 0; second frame shows it digit by digit.
        for (int k = 0; k < 32; k++) begin
            cyc(1'b1, k == 0, 16'h4321, 1'b0);
            if (k >= 16) begin
                check("seq_an", {12'h0, an}, {12'h0, an_tab[k-16]});
                check("seq_bcd", {12'h0, bcd}, {12'h0, bcd_tab[k-16]});
            end
            if (k == 14) check("fd_before", {15'h0, frame_done}, 16'h0);
            if (k == 15 || k == 31) check("fd_pulse", {15'h0, frame_done}, 16'h1);
        end

        // Leading-zero suppression with 0050, then with 0000.
        cyc(1'b1, 1'b1, 16'h0050, 1'b1);
        repeat (15) cyc(1'b1, 1'b0, 16'h0, 1'b1);
        n_hi = 0; n1 = 0; n0 = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b1);
            if (!an[3] || !an[2]) n_hi++;
            if (an == 4'b1101 && bcd == 4'd5) n1++;
            if (an == 4'b1110 && bcd == 4'd0) n0++;
        end
        check("lz_hi_dark", 16'(n_hi), 16'd0);
        check("lz_d1_lit", 16'(n1), 16'd3);
        check("lz_d0_lit", 16'(n0), 16'd3);
        cyc(1'b1, 1'b1, 16'h0000, 1'b1);
        repeat (15) cyc(1'b1, 1'b0, 16'h0, 1'b1);
        n0 = 0; n_other = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b1);
            if (an == 4'b1110) n0++;
            else if (an != 4'b1111) n_other++;
        end
        check("lz_zero_d0", 16'(n0), 16'd3);
        check("lz_zero_other", 16'(n_other), 16'd0);

        // No tearing: 2222 loaded mid-frame appears only in the following frame.
        cyc(1'b1, 1'b1, 16'h1111, 1'b0);
        repeat (15) cyc(1'b1, 1'b0, 16'h0, 1'b0);
        n_bad1 = 0; n_bad2 = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, k == 5, 16'h2222, 1'b0);
            if (bcd != 4'd1) n_bad1++;
        end
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b0);
            if (bcd != 4'd2) n_bad2++;
        end
        check("tear_frame1", 16'(n_bad1), 16'd0);
        check("tear_frame2", 16'(n_bad2), 16'd0);

        // Pause at cnt=2 of digit 1, then resume.
        repeat (6) cyc(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, 16'h0, 1'b0);
            check("pause_an", {12'h0, an}, 16'hF);
        end
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        check("resume_c2", {12'h0, an}, 16'hD);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        check("resume_c3", {12'h0, an}, 16'hD);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        check("resume_d2_blank", {12'h0, an}, 16'hF);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        check("resume_d2_lit", {12'h0, an}, 16'hB);

        // Asynchronous reset mid-frame with data pending.
        cyc(1'b1, 1'b1, 16'h9999, 1'b0);
        cyc(1'b1, 1'b0, 16'h0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_an", {12'h0, an}, 16'hF);
        check("async_bcd", {12'h0, bcd}, 16'h0);
        check("async_fd", {15'h0, frame_done}, 16'h0);
        repeat (2) cyc(1'b1, 1'b0, 16'h0, 1'b0);
        rst_n = 1'b1;
        n_other = 0;
        for (int k = 0; k < 32; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b0);
            if (k == 0) check("post_rst_blank", {12'h0, an}, 16'hF);
            if (bcd != 4'd0) n_other++;
        end
        check("pending_lost", 16'(n_other), 16'd0);

        // Non-BCD codes pass through unchanged.
        cyc(1'b1, 1'b1, 16'hFA98, 1'b0);
        repeat (15) cyc(1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 1'b0);
            if (k == 1)  check("hex_d0", {12'h0, bcd}, 16'h8);
            if (k == 5)  check("hex_d1", {12'h0, bcd}, 16'h9);
            if (k == 9)  check("hex_d2", {12'h0, bcd}, 16'hA);
            if (k == 13) check("hex_d3", {12'h0, bcd}, 16'hF);
            if (k == 15) check("hex_fd", {15'h0, frame_done}, 16'h1);
        end

        // Random traffic against the model.
        lz_r = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) lz_r = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if ($urandom_range(0, 1) == 1) d = d >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                check("rand_async_an", {12'h0, an}, 16'hF);
                cyc(1'b1, 1'b0, d, lz_r);
                rst_n = 1'b1;
            end else begin
                cyc($urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0, d, lz_r);
            end
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
